// File: rtl/num_split.sv
// num_split: iterative double-dabble splitter. Turns a WIDTH-bit unsigned result
// into DIGITS BCD digits plus its two raw nibbles, one shift per clock, with a
// start/busy/done handshake. All outputs are registered.
module num_split #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      num_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [WIDTH/2-1:0]    lo_nib,
   output logic [WIDTH/2-1:0]    hi_nib
);

   localparam int BW = 4 * DIGITS;
   localparam int HW = WIDTH / 2;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_sh;     // bits still to be shifted into the accumulator
   logic [WIDTH-1:0] r_lat;    // untouched copy of the input for the nibble outputs
   logic [BW-1:0]    r_acc;    // BCD accumulator
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [BW-1:0]    r_bcd;
   logic [HW-1:0]    r_lo;
   logic [HW-1:0]    r_hi;

   logic [BW-1:0]    w_corr;
   logic [BW-1:0]    w_acc_nxt;

   // Add-3 correction on every digit >= 5, all digits judged on pre-correction values
   always_comb begin
      w_corr = r_acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_acc[4*d +: 4] >= 4'd5)
            w_corr[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
   end

   // Corrected accumulator shifted left; shift-register MSB enters the ones LSB.
   // The top digit never overflows, so the bit shifted out is always zero.
   assign w_acc_nxt = (w_corr << 1) | {{(BW-1){1'b0}}, r_sh[WIDTH-1]};

   // Control FSM, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sh    <= '0;
         r_lat   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_bcd   <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sh    <= num_in;
                  r_lat   <= num_in;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // start is ignored here; the in-flight conversion runs to completion
               r_acc <= w_acc_nxt;
               r_sh  <= r_sh << 1;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_bcd   <= w_acc_nxt;
                  r_lo    <= r_lat[HW-1:0];
                  r_hi    <= r_lat[WIDTH-1:HW];
               end
            end
            S_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  // back-to-back request accepted in the done cycle
                  r_sh    <= num_in;
                  r_lat   <= num_in;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign bcd_out = r_bcd;
   assign lo_nib  = r_lo;
   assign hi_nib  = r_hi;

endmodule

// File: tb/tb_num_split.sv
// Bench for num_split: a cycle-level reference model derived from the
// handshake timing and decimal arithmetic, checked every cycle, plus
// directed vectors with hand-computed literal results.
module tb_num_split;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [7:0]       num_in = 8'h00;
   logic             busy;
   logic             done;
   logic [11:0]      bcd_out;
   logic [3:0]       lo_nib;
   logic [3:0]       hi_nib;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   num_split #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_in(num_in),
      .busy(busy), .done(done), .bcd_out(bcd_out),
      .lo_nib(lo_nib), .hi_nib(hi_nib)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input int v);
      return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   // Reference model: a conversion occupies WIDTH cycles after acceptance,
   // then results appear together with a one-cycle done.
   int         m_rem = 0;
   logic [7:0] m_val = 8'h00;
   logic       m_done = 1'b0;
   logic [11:0] m_bcd = 12'h000;
   logic [3:0] m_hi = 4'h0;
   logic [3:0] m_lo = 4'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem  <= 0;
         m_done <= 1'b0;
         m_bcd  <= 12'h000;
         m_hi   <= 4'h0;
         m_lo   <= 4'h0;
      end else begin
         m_done <= (m_rem == 1);
         if (m_rem == 1) begin
            m_bcd <= to_bcd(int'(m_val));
            m_hi  <= m_val[7:4];
            m_lo  <= m_val[3:0];
         end
         if (m_rem != 0) m_rem <= m_rem - 1;
         else if (start) begin
            m_rem <= WIDTH;
            m_val <= num_in;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (chk_en) begin
            n_vec++;
            if (busy !== (m_rem != 0) || done !== m_done || bcd_out !== m_bcd ||
                hi_nib !== m_hi || lo_nib !== m_lo) begin
               n_err++;
               $display("FAIL cycle t=%0t: busy/done/bcd/hi/lo got %b/%b/%h/%h/%h expected %b/%b/%h/%h/%h",
                        $time, busy, done, bcd_out, hi_nib, lo_nib,
                        (m_rem != 0), m_done, m_bcd, m_hi, m_lo);
            end
         end
      end
   endtask

   // Issue one conversion; returns number of negedges until done (0 on timeout)
   task automatic convert(input logic [7:0] v, output int lat);
      int k;
      bit got;
      @(negedge clk); #1;
      start = 1'b1; num_in = v;
      k = 0; got = 1'b0;
      while (!got && k < 20) begin
         @(negedge clk);
         k++;
         if (done === 1'b1) got = 1'b1;
         #1 start = 1'b0;
      end
      lat = got ? k : 0;
   endtask

   int lat;
   int ndone;

   initial begin
      fork monitor(); join_none

      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset_bcd", int'(bcd_out), 0);
      check("reset_busy_done", int'({busy, done}), 0);
      #1 rst_n = 1'b1;

      // 0x00: done on 9th edge
      convert(8'h00, lat);
      check("lat_00", lat, 9);
      check("bcd_00", int'(bcd_out), 12'h000);
      check("nib_00", int'({hi_nib, lo_nib}), 8'h00);

      // 0xFF and done width
      convert(8'hFF, lat);
      check("lat_ff", lat, 9);
      check("bcd_ff", int'(bcd_out), 12'h255);
      check("nib_ff", int'({hi_nib, lo_nib}), 8'hFF);
      @(negedge clk);
      check("done_width_ff", int'(done), 0);
      check("hold_ff", int'(bcd_out), 12'h255);

      // 0x9C with start held during SHIFT carrying 0x01
      @(negedge clk); #1 start = 1'b1; num_in = 8'h9C;
      @(negedge clk); #1 num_in = 8'h01;
      repeat (5) @(negedge clk);
      #1 start = 1'b0;
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            check("bcd_9c", int'(bcd_out), 12'h156);
            check("nib_9c", int'({hi_nib, lo_nib}), 8'h9C);
         end
      end
      check("ndone_9c", ndone, 1);

      // Back-to-back 0x63 then 0x64
      convert(8'h63, lat);
      check("bcd_63", int'(bcd_out), 12'h099);
      #1 start = 1'b1; num_in = 8'h64;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         if (done === 1'b1) lat = k;
         #1 start = 1'b0;
      end
      check("b2b_spacing", lat, 9);
      check("bcd_64", int'(bcd_out), 12'h100);

      // Reset mid-conversion of 0xC8
      @(negedge clk); #1 start = 1'b1; num_in = 8'hC8;
      @(negedge clk); #1 start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_bcd", int'(bcd_out), 0);
      check("rst_mid_flags", int'({busy, done, hi_nib, lo_nib}), 0);
      @(negedge clk); #1 rst_n = 1'b1;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      check("no_done_after_rst", ndone, 0);
      convert(8'hC8, lat);
      check("lat_c8", lat, 9);
      check("bcd_c8", int'(bcd_out), 12'h200);

      // Full sweep
      for (int v = 0; v < 256; v++) begin
         convert(8'(v), lat);
         check("sweep_lat", lat, 9);
         check("sweep_bcd", int'(bcd_out), int'(to_bcd(v)));
         check("sweep_nib", int'({hi_nib, lo_nib}), v);
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
